// File: rtl/counter_pkg.sv
// Shared encodings for the programmable-modulo counter.
//   mode_t  : operating mode as presented on the 2-bit mode input
//             (encoding 3 is reserved and behaves as MODE_WRAP)
//   state_t : one-shot run FSM state
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/modulo_counter.sv
// Programmable-modulo up/down counter with synchronous load and three modes:
// wrap, saturate and one-shot. Used as a timebase / event counter.
//
// Ports:
//   clock    in   1     sole clock, all state changes on posedge
//   reset    in   1     asynchronous active-high reset
//   enable   in   1     take one count step this cycle
//   up       in   1     1 = count up, 0 = count down
//   mode     in   2     0 wrap, 1 saturate, 2 one-shot, 3 behaves as wrap
//   limit    in   Size  terminal value, count range is 0..limit
//   load     in   1     synchronous load of load_val (highest priority)
//   load_val in   Size  value loaded when load=1
//   start    in   1     one-shot: arm and begin (or restart) a run
//   clr_ovf  in   1     clear sticky overflow (a same-edge set wins)
//   count    out  Size  registered count
//   tc       out  1     one-cycle terminal-count pulse
//   overflow out  1     sticky wrap/clamp flag (wrap and saturate modes)
//   busy     out  1     one-shot run in progress
//   done     out  1     one-shot run finished
//
// Handshake: there is none; every input is a plain level sampled at each
// posedge, and every output is a register updated by that same edge.
module modulo_counter
  import counter_pkg::*;
#(
  parameter int Size     = 5,
  parameter int ResetVal = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic [1:0]      mode,
  input  logic [Size-1:0] limit,
  input  logic            load,
  input  logic [Size-1:0] load_val,
  input  logic            start,
  input  logic            clr_ovf,
  output logic [Size-1:0] count,
  output logic            tc,
  output logic            overflow,
  output logic            busy,
  output logic            done
);

  state_t          state, state_d;
  logic [Size-1:0] count_d;
  logic            tc_d;
  logic            ovf_d;

  logic            oneshot;
  logic            saturating;
  logic            launch;
  logic            step;
  logic            up_term;
  logic            dn_term;
  logic            term_evt;
  logic            finish;

  // Step qualification shared by the count path and the FSM.
  always_comb begin
    oneshot    = (mode == MODE_ONESHOT);
    saturating = (mode == MODE_SAT) || oneshot;
    launch     = oneshot && start && !load;
    // In one-shot mode the counter only moves while a run is active;
    // idle and finished runs ignore enable.
    step       = enable && !load && !launch && (!oneshot || state == ST_RUN);
    up_term    = (count >= limit);
    dn_term    = (count == '0);
    term_evt   = step && (up ? up_term : dn_term);
    // A run finishes on the step that lands on the terminal value, or on a
    // step taken while already at/beyond it (e.g. after a load).
    finish     = oneshot && step &&
                 (up ? (up_term || (Size'(count + 1'b1) == limit))
                     : (dn_term || (count == Size'(1))));
  end

  // Next count, terminal pulse and sticky overflow.
  always_comb begin
    count_d = count;
    tc_d    = 1'b0;
    ovf_d   = clr_ovf ? 1'b0 : overflow;
    if (load) begin
      count_d = load_val;
    end else if (launch) begin
      count_d = up ? '0 : limit;
    end else if (step) begin
      if (up) begin
        if (up_term) count_d = saturating ? limit : '0;
        else         count_d = count + 1'b1;
      end else begin
        if (dn_term) count_d = saturating ? '0 : limit;
        else         count_d = count - 1'b1;
      end
    end
    tc_d = oneshot ? finish : term_evt;
    // Set dominates clear; one-shot clamps are reported via done, not here.
    if (term_evt && !oneshot) ovf_d = 1'b1;
  end

  // One-shot run FSM. Leaving one-shot mode forces IDLE; entering it from
  // another mode finds the FSM already idle.
  always_comb begin
    state_d = state;
    if (!oneshot) begin
      state_d = ST_IDLE;
    end else if (launch) begin
      state_d = ST_RUN;
    end else if (state == ST_RUN && finish) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= Size'(ResetVal);
      tc       <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      tc       <= tc_d;
      overflow <= ovf_d;
      busy     <= (state_d == ST_RUN);
      done     <= (state_d == ST_DONE);
    end
  end

endmodule
